stft_pw2_multi: RTL
===================

Name: stft_pw2_multi

Overview:
Parametrised successor of the two-engine ping-pong STFT power stage. It sits between the window buffer and N_ENG external FFT engines.
- Dispatches whole windowed frames to the engines in strict round-robin order.
- Collects engine outputs in the same frame order.
- Computes |X|^2 through a 3-stage pipeline with runtime right-shift and saturation to OUT_WIDTH.
- Tags each output with bin index, start/end-of-frame markers and a frame counter.

Parameters:
WIDTH, 16, signed re/im sample width on window and engine buses
N_FFT, 512, frame length in samples and bins (power of 2, >=8)
N_ENG, 2, number of FFT engines served (2..8)
OUT_WIDTH, 32, power output width (WIDTH+1 .. 2*WIDTH+1)
FCNT_W, 16, frame counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
win_en  in  1  windowed sample valid
win_re / win_im  in  WIDTH  windowed sample, signed
win_rdy  out  1  sample accepted when win_en & win_rdy
eng_rdy  in  N_ENG  engine i can start a new frame
eng_di_en  out  N_ENG  one-hot input enable to engine i
eng_di_re / eng_di_im  out  WIDTH  shared input data bus, registered
eng_do_en  in  N_ENG  engine i output valid
eng_do_re / eng_do_im  in  N_ENG*WIDTH  packed engine outputs; engine i occupies slice [i*WIDTH +: WIDTH]
pw_shift  in  $clog2(2*WIDTH+1)  right shift applied before saturation; sampled per sample
pw_en  out  1  power output valid
pw_data  out  OUT_WIDTH  saturated power
pw_bin  out  $clog2(N_FFT)  bin index of pw_data
pw_sof / pw_eof  out  1  first / last emitted bin of frame
pw_sat  out  1  pw_data saturated this sample
frame_cnt  out  FCNT_W  completed output frames, wraps
order_err  out  1  sticky protocol error

Behaviour:
- Reset: clk and rst_n as named above; reset is asynchronous, active-low.
  - All outputs are 0, and win_rdy is 0 during reset.
  - Write pointer, read pointer and counters go to 0. Partial frames in flight are discarded.
  - order_err clears only on reset.
- Dispatcher FSM:
  - D_IDLE: win_rdy = eng_rdy[wr_ptr]. On the first accepted sample, go to D_FEED and set in_cnt=1.
  - D_FEED: win_rdy=1. Accept sample, in_cnt++. When in_cnt reaches N_FFT-1 and that sample is accepted, wr_ptr advances (wraps at N_ENG-1 to 0) and the FSM returns to D_IDLE.
  - Engine data path: eng_di_en[wr_ptr], eng_di_re and eng_di_im are registered. There is 1 cycle latency from acceptance; all other enables are 0.
  - No engine is skipped. If eng_rdy[wr_ptr]=0, input stalls even when other engines are ready.
  - Gaps (win_en=0) mid-frame are allowed; the engine sees no enable for those cycles.
- Collector:
  - Only eng_do_en[rd_ptr] is consumed, and out_cnt increments on each consumed sample.
  - At out_cnt=N_FFT-1: rd_ptr advances (wraps), out_cnt returns to 0, frame_cnt increments on the same cycle as pw_eof.
  - Error: any eng_do_en[j] with j != rd_ptr sets order_err. That sample is dropped and the counters are unaffected.
  - Simultaneous valid from rd_ptr and another engine: consume rd_ptr, flag the error.
- Power pipeline, latency exactly 3 cycles from eng_do_en to pw_en:
  - S1: register the selected re/im and the bin tag.
  - S2: re*re, im*im as signed 2*WIDTH products.
  - S3: sum into unsigned 2*WIDTH+1 bits, then >> pw_shift.
  - Saturation: if the result is >= 2^OUT_WIDTH, pw_data = all ones and pw_sat=1.
  - Full-rate: a new sample is accepted every cycle, with no output backpressure.
- pw_sof is asserted with bin 0 and pw_eof with the last emitted bin. For N_FFT bins, both can never be asserted on the same sample.

Optional Feature:
STFT_ONESIDED_EN
- Defined: only bins 0..N_FFT/2 are emitted; pw_eof is on bin N_FFT/2. Bins N_FFT/2+1..N_FFT-1 are still consumed and counted but give pw_en=0. frame_cnt increments on the pw_eof cycle.
- Undefined: all N_FFT bins are emitted; pw_eof is on bin N_FFT-1.

Decomposition:
- Package stft_pkg holds:
  - BIN_W=$clog2(N_FFT) and SH_W=$clog2(2*WIDTH+1) helper constants
  - dispatcher state encoding {D_IDLE, D_FEED}
  - saturation helper function sat_shift
- One sub-module, stft_pw2_pipe: the 3-stage square/sum/shift/saturate pipeline, which carries the tag fields (bin, sof, eof) alongside the data.
- Dispatcher and collector stay in the top level.

Test Plan:
All scenarios use N_FFT=16, N_ENG=3, WIDTH=16, OUT_WIDTH=32.
- Round-robin: stream 6 frames with all eng_rdy=1 -> eng_di_en is one-hot 001,010,100,001,010,100 per frame, each asserted exactly 16 cycles.
- Stall: eng_rdy=3'b101 with wr_ptr=1 at frame start -> win_rdy=0 and no enables; raising eng_rdy[1] -> frame starts next cycle on engine 1.
- Arithmetic: re=3, im=-4 -> pw_data=25 three cycles later. Worst case re=im=-32768, pw_shift=0 -> 0x80000000, pw_sat=0.
- Saturation, with OUT_WIDTH=24: re=im=-32768, pw_shift=0 -> 0xFFFFFF, pw_sat=1. Same input with pw_shift=8 -> 0x800000, pw_sat=0.
- Ordering error: engine 2 asserts eng_do_en while rd_ptr=0 -> order_err=1 (sticky), no pw_en, and engine 0's frame is still output intact with bins 0..15.
- Reset mid-frame: assert rst_n=0 at in_cnt=7 -> all outputs 0 immediately. After release the next frame goes to engine 0 and frame_cnt=0. With STFT_ONESIDED_EN, 9 pw_en per frame and pw_eof on bin 8.

Source files
------------

// File: rtl/stft_pkg.sv
// Shared types and helpers for the STFT power stage: dispatcher state encoding,
// width helpers and the shift/saturate function used by the power pipeline.
package stft_pkg;

  // Widest |X|^2 sum for WIDTH <= 32 (65 bits), plus one spare bit above it.
  localparam int unsigned MAXW = 66;

  typedef enum logic {
    D_IDLE,
    D_FEED
  } disp_state_e;

  typedef struct packed {
    logic            sat;
    logic [MAXW-1:0] data;
  } sat_res_t;

  function automatic int unsigned bin_w(input int unsigned n_fft);
    return $clog2(n_fft);
  endfunction

  function automatic int unsigned sh_w(input int unsigned width);
    return $clog2(2 * width + 1);
  endfunction

  // Shift right, then clamp to an ow-bit all-ones value when the result does not fit.
  function automatic sat_res_t sat_shift(input logic [MAXW-1:0] sum,
                                         input int unsigned     sh,
                                         input int unsigned     ow);
    sat_res_t        res;
    logic [MAXW-1:0] shifted;
    shifted  = sum >> sh;
    res.sat  = ((shifted >> ow) != '0);
    res.data = res.sat ? ({MAXW{1'b1}} >> (MAXW - ow)) : shifted;
    return res;
  endfunction

endpackage

// File: rtl/stft_pw2_pipe.sv
// Three-stage |X|^2 pipeline: register, square, sum/shift/saturate.
// Bin, start- and end-of-frame tags travel alongside the data.
module stft_pw2_pipe
  import stft_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int N_FFT     = 512,
  parameter int OUT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_en,
  input  logic signed [WIDTH-1:0]     i_re,
  input  logic signed [WIDTH-1:0]     i_im,
  input  logic [bin_w(N_FFT)-1:0]     i_bin,
  input  logic                        i_sof,
  input  logic                        i_eof,
  input  logic [sh_w(WIDTH)-1:0]      i_shift,
  output logic                        o_eof_next,
  output logic                        o_en,
  output logic [OUT_WIDTH-1:0]        o_data,
  output logic [bin_w(N_FFT)-1:0]     o_bin,
  output logic                        o_sof,
  output logic                        o_eof,
  output logic                        o_sat
);
  localparam int BIN_W = bin_w(N_FFT);
  localparam int SH_W  = sh_w(WIDTH);

  logic                      r_v1, r_sof1, r_eof1, r_v2, r_sof2, r_eof2;
  logic [BIN_W-1:0]          r_bin1, r_bin2;
  logic signed [WIDTH-1:0]   r_re1, r_im1;
  logic [SH_W-1:0]           r_sh1, r_sh2;
  logic signed [2*WIDTH-1:0] r_pre2, r_pim2;
  logic signed [2*WIDTH-1:0] w_re_ext, w_im_ext;
  logic [2*WIDTH:0]          w_sum;
  logic                      w_sat;
  logic [MAXW-OUT_WIDTH-1:0] w_unused_hi;
  logic [OUT_WIDTH-1:0]      w_pw;

  assign w_re_ext = (2*WIDTH)'(r_re1);
  assign w_im_ext = (2*WIDTH)'(r_im1);
  // Both squares are non-negative, so they add as unsigned with one carry bit.
  assign w_sum    = {1'b0, r_pre2} + {1'b0, r_pim2};
  assign {w_sat, w_unused_hi, w_pw} = sat_shift(MAXW'(w_sum), 32'(r_sh2), OUT_WIDTH);
  assign o_eof_next = r_v2 & r_eof2;

  // NOTE: datapath stages carry no reset; only valid and tag bits need a defined value.
  always_ff @(posedge clk) begin
    r_re1  <= i_re;
    r_im1  <= i_im;
    r_sh1  <= i_shift;
    r_pre2 <= w_re_ext * w_re_ext;
    r_pim2 <= w_im_ext * w_im_ext;
    r_sh2  <= r_sh1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_v1, r_sof1, r_eof1, r_v2, r_sof2, r_eof2} <= '0;
      r_bin1 <= '0;
      r_bin2 <= '0;
      o_en   <= 1'b0;
      o_data <= '0;
      o_bin  <= '0;
      o_sof  <= 1'b0;
      o_eof  <= 1'b0;
      o_sat  <= 1'b0;
    end else begin
      r_v1   <= i_en;
      r_sof1 <= i_sof;
      r_eof1 <= i_eof;
      r_bin1 <= i_bin;
      r_v2   <= r_v1;
      r_sof2 <= r_sof1;
      r_eof2 <= r_eof1;
      r_bin2 <= r_bin1;
      o_en   <= r_v2;
      o_sof  <= r_v2 & r_sof2;
      o_eof  <= r_v2 & r_eof2;
      o_sat  <= r_v2 & w_sat;
      if (r_v2) begin
        o_data <= w_pw;
        o_bin  <= r_bin2;
      end
    end
  end

endmodule

// File: rtl/stft_pw2_multi.sv
// STFT power stage: round-robin frame dispatch to N_ENG FFT engines, in-order collection
// and tagged |X|^2 output. Build option STFT_ONESIDED_EN emits only bins 0..N_FFT/2.
module stft_pw2_multi
  import stft_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int N_FFT     = 512,
  parameter int N_ENG     = 2,
  parameter int OUT_WIDTH = 32,
  parameter int FCNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      win_en,
  input  logic signed [WIDTH-1:0]   win_re,
  input  logic signed [WIDTH-1:0]   win_im,
  output logic                      win_rdy,
  input  logic [N_ENG-1:0]          eng_rdy,
  output logic [N_ENG-1:0]          eng_di_en,
  output logic signed [WIDTH-1:0]   eng_di_re,
  output logic signed [WIDTH-1:0]   eng_di_im,
  input  logic [N_ENG-1:0]          eng_do_en,
  input  logic [N_ENG*WIDTH-1:0]    eng_do_re,
  input  logic [N_ENG*WIDTH-1:0]    eng_do_im,
  input  logic [sh_w(WIDTH)-1:0]    pw_shift,
  output logic                      pw_en,
  output logic [OUT_WIDTH-1:0]      pw_data,
  output logic [bin_w(N_FFT)-1:0]   pw_bin,
  output logic                      pw_sof,
  output logic                      pw_eof,
  output logic                      pw_sat,
  output logic [FCNT_W-1:0]         frame_cnt,
  output logic                      order_err
);
  localparam int BIN_W = bin_w(N_FFT);
  localparam int PTR_W = $clog2(N_ENG);

  disp_state_e       r_state;
  logic              r_run;
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [BIN_W-1:0]  r_in_cnt, r_out_cnt;
  logic [FCNT_W-1:0] r_frame_cnt;
  logic              r_order_err;
  logic              w_acc, w_sel, w_err, w_emit, w_eof_next;
  logic [N_ENG-1:0]  w_wr_oh, w_rd_oh;
  logic [WIDTH-1:0]  w_sel_re, w_sel_im;

`ifdef STFT_ONESIDED_EN
  localparam int LAST_EMIT = N_FFT / 2;
  assign w_emit = (r_out_cnt <= BIN_W'(LAST_EMIT));
`else
  localparam int LAST_EMIT = N_FFT - 1;
  assign w_emit = 1'b1;
`endif

  // r_run is cleared asynchronously so win_rdy is low throughout reset.
  assign win_rdy  = r_run & ((r_state == D_FEED) | eng_rdy[r_wr_ptr]);
  assign w_acc    = win_en & win_rdy;
  assign w_wr_oh  = N_ENG'(1) << r_wr_ptr;
  assign w_rd_oh  = N_ENG'(1) << r_rd_ptr;
  assign w_sel    = |(eng_do_en & w_rd_oh);
  assign w_err    = |(eng_do_en & ~w_rd_oh);
  assign w_sel_re = eng_do_re[int'(r_rd_ptr)*WIDTH +: WIDTH];
  assign w_sel_im = eng_do_im[int'(r_rd_ptr)*WIDTH +: WIDTH];
  assign frame_cnt = r_frame_cnt;
  assign order_err = r_order_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  // NOTE: non-blocking assignments everywhere in clocked blocks, so each register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= D_IDLE;
      r_wr_ptr  <= '0;
      r_in_cnt  <= '0;
      eng_di_en <= '0;
      eng_di_re <= '0;
      eng_di_im <= '0;
    end else begin
      eng_di_en <= w_acc ? w_wr_oh : '0;
      if (w_acc) begin
        eng_di_re <= win_re;
        eng_di_im <= win_im;
      end
      case (r_state)
        D_IDLE: if (w_acc) begin
          r_state  <= D_FEED;
          r_in_cnt <= BIN_W'(1);
        end
        D_FEED: if (w_acc) begin
          if (r_in_cnt == BIN_W'(N_FFT - 1)) begin
            r_state  <= D_IDLE;
            r_in_cnt <= '0;
            r_wr_ptr <= (r_wr_ptr == PTR_W'(N_ENG - 1)) ? '0 : r_wr_ptr + 1'b1;
          end else begin
            r_in_cnt <= r_in_cnt + 1'b1;
          end
        end
        default: r_state <= D_IDLE;
      endcase
    end
  end

  // Only the engine owning the current output frame is consumed; strays are dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_out_cnt   <= '0;
      r_order_err <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_err) r_order_err <= 1'b1;
      if (w_sel) begin
        if (r_out_cnt == BIN_W'(N_FFT - 1)) begin
          r_out_cnt <= '0;
          r_rd_ptr  <= (r_rd_ptr == PTR_W'(N_ENG - 1)) ? '0 : r_rd_ptr + 1'b1;
        end else begin
          r_out_cnt <= r_out_cnt + 1'b1;
        end
      end
      if (w_eof_next) r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  stft_pw2_pipe #(
    .WIDTH    (WIDTH),
    .N_FFT    (N_FFT),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_sel & w_emit),
    .i_re      (w_sel_re),
    .i_im      (w_sel_im),
    .i_bin     (r_out_cnt),
    .i_sof     (r_out_cnt == '0),
    .i_eof     (r_out_cnt == BIN_W'(LAST_EMIT)),
    .i_shift   (pw_shift),
    .o_eof_next(w_eof_next),
    .o_en      (pw_en),
    .o_data    (pw_data),
    .o_bin     (pw_bin),
    .o_sof     (pw_sof),
    .o_eof     (pw_eof),
    .o_sat     (pw_sat)
  );

endmodule
